csr_file_m: RTL and testbench
=============================

Name: csr_file_m

Overview:
Parametrised machine-mode CSR file, successor to the single-timer CSR block. Adds:
- atomic CSRRW/CSRRS/CSRRC semantics and per-register write masks;
- a configurable count of platform interrupt lines with a fixed priority encoder;
- vectored mtvec, mtval, and 64-bit mcycle/minstret counters.

It sits beside the decode/execute stage in core.v. It supplies the trap target, interrupt request/cause and mepc to the pipeline.

Parameters:
NUM_PLAT_IRQ, 4, platform interrupt lines, mapped to mip/mie bits 16+i (1..16)
CNT_WIDTH, 64, width of mcycle/minstret (32 or 64)
MTVEC_RESET, 32'h00000100, reset value of mtvec (direct mode)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
csr_addr  in  12  CSR address
csr_wdata  in  32  write operand (rs1 or zero-extended imm)
csr_we  in  1  CSR instruction valid this cycle
csr_op  in  2  01 RW, 10 RS, 11 RC, 00 no write
csr_rdata  out  32  old value of addressed CSR (combinational)
csr_illegal  out  1  unimplemented address or write to read-only CSR
trap_in  in  1  take trap this cycle
trap_pc  in  32  PC saved to mepc
trap_cause  in  32  cause saved to mcause
trap_tval  in  32  value saved to mtval
mret_taken  in  1  MRET executed
instr_retire  in  1  one instruction retired
timer_int_raw  in  1  mtime >= mtimecmp
sw_int_raw  in  1  software interrupt (msip)
ext_int_raw  in  1  machine external interrupt
plat_irq  in  NUM_PLAT_IRQ  platform interrupt lines
irq_pending  out  1  enabled interrupt pending and mstatus.MIE=1
irq_cause  out  32  mcause value for the highest-priority pending interrupt
trap_target  out  32  next PC for trap_in using trap_cause
mepc  out  32  mepc register
mstatus_mie  out  1  mstatus[3]

Behaviour:
- Reset: all CSRs 0 except mtvec=MTVEC_RESET. Outputs: irq_pending=0, irq_cause=0, mepc=0, mstatus_mie=0, trap_target=MTVEC_RESET.
- Write value: RW=wdata; RS=old|wdata; RC=old&~wdata. Write occurs when csr_we=1, csr_op!=00, and the access is legal. Register updates at the next posedge.
- Priority in one cycle: trap_in > mret_taken > CSR write. A CSR write in a trap/mret cycle is dropped.
- Trap: mepc<=trap_pc&~1, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0.
- MRET: MIE<=MPIE, MPIE<=1.
- mstatus 0x300: only bits 3 and 7 are writable; bits 12:11 read 2'b11; all other bits read 0.
- mie 0x304: writable bits 3, 7, 11, 16..16+NUM_PLAT_IRQ-1; all others read 0.
- mip 0x344: read-only to software; writes are ignored (not illegal).
  - mip bit 3 = sw_int_raw, bit 7 = timer_int_raw, bit 11 = ext_int_raw, bit 16+i = plat_irq[i].
  - Each bit is registered one cycle from its input.
- mtvec 0x305:
  - MODE = bits 1:0, BASE = bits 31:2.
  - A write with MODE 2 or 3 updates BASE and keeps the old MODE.
- mscratch 0x340, mepc 0x341 (bit0 forced 0), mcause 0x342, mtval 0x343: fully software-writable.
- trap_target: BASE<<2 if MODE=0 or trap_cause[31]=0; otherwise (BASE<<2)+4*trap_cause[4:0].
- Interrupt arbitration:
  - pend = mip & mie.
  - Priority: 11 > 3 > 7 > 16 > 17 ...; lowest platform index wins.
  - irq_cause = {1'b1, 26'b0, code[4:0]}; irq_cause=0 when pend=0.
  - irq_pending = mstatus.MIE & |pend.
  - Latency: input rises in cycle N -> irq_pending=1 in cycle N+1.
- Counters:
  - mcycle (0xB00 low, 0xB80 high) increments every cycle.
  - minstret (0xB02/0xB82) increments when instr_retire=1.
  - A software write to either half replaces that half; the increment of that counter is suppressed that cycle.
  - Wrap from all-ones to 0.
  - CNT_WIDTH=32: high halves read 0 and writes to them are ignored.
  - Read-only shadows: 0xC00/0xC80/0xC02/0xC82.
  - Counters keep running during trap/mret cycles.
- csr_illegal (combinational):
  - Asserted for any unimplemented address.
  - Asserted when csr_op!=00 and csr_addr[11:10]=2'b11.
  - An illegal access has no side effect; csr_rdata=0.
- Reset asserted mid-operation clears state immediately (asynchronous). First update happens at the first posedge after release.

Optional Feature:
CSR_MCOUNTINHIBIT_EN:
- Defined: mcountinhibit at 0x320. Bit0 (CY) freezes mcycle; bit2 (IR) freezes minstret. Other bits read 0. Software writes to the counters still apply while inhibited.
- Undefined: 0x320 is unimplemented (csr_illegal=1) and the counters always run.

Test Plan:
- RW/RS/RC on mscratch: write 0xF0F0_0000, RS 0x0000_00FF, RC 0xF000_0000 -> reads return the old value each time; final value 0x00F0_00FF.
- mie=0x0001_0880, mstatus=0x8, raise plat_irq[0]+timer_int_raw+ext_int_raw together -> irq_pending=1 one cycle later, irq_cause=0x8000_000B; drop ext -> 0x8000_0007; drop timer -> 0x8000_0010.
- mtvec=0x0000_0201, trap_in with trap_cause=0x8000_0007, trap_pc=0x1234 -> trap_target=0x0000_021C, mepc=0x1234, MIE 1->0, MPIE=1; then mret_taken -> MIE=1.
- Trap and csrw mepc=0x5555 in the same cycle -> mepc=trap_pc, and the write is dropped.
- mcycle low=0xFFFF_FFFF, high=0 -> two cycles later low=1, high=1. Write to 0xC00 -> csr_illegal=1 and no change.
- With CSR_MCOUNTINHIBIT_EN: write 0x320=0x5 -> mcycle and minstret hold for 10 cycles with instr_retire=1. Write 0 -> both resume.

Source files
------------

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file with atomic RW/RS/RC access, interrupt arbitration,
// vectored mtvec and mcycle/minstret counters. Define CSR_MCOUNTINHIBIT_EN to add mcountinhibit (0x320).
module csr_file_m #(
    parameter int unsigned NUM_PLAT_IRQ = 4,
    parameter int unsigned CNT_WIDTH    = 64,
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             csr_addr,
    input  logic [31:0]             csr_wdata,
    input  logic                    csr_we,
    input  logic [1:0]              csr_op,
    output logic [31:0]             csr_rdata,
    output logic                    csr_illegal,
    input  logic                    trap_in,
    input  logic [31:0]             trap_pc,
    input  logic [31:0]             trap_cause,
    input  logic [31:0]             trap_tval,
    input  logic                    mret_taken,
    input  logic                    instr_retire,
    input  logic                    timer_int_raw,
    input  logic                    sw_int_raw,
    input  logic                    ext_int_raw,
    input  logic [NUM_PLAT_IRQ-1:0] plat_irq,
    output logic                    irq_pending,
    output logic [31:0]             irq_cause,
    output logic [31:0]             trap_target,
    output logic [31:0]             mepc,
    output logic                    mstatus_mie
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MCNTINH   = 12'h320;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;

    localparam logic [31:0] MIE_MASK    = 32'h0000_0888 | (((32'h1 << NUM_PLAT_IRQ) - 32'h1) << 16);
    localparam logic [63:0] CNT_MASK    = (CNT_WIDTH == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
    localparam logic        HI_WRITABLE = (CNT_WIDTH == 64);

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mip_q, mip_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
`ifdef CSR_MCOUNTINHIBIT_EN
    logic [1:0]  inhibit_q, inhibit_d;   // {IR, CY}
`endif

    logic [31:0] mstatus_rd;
    logic [31:0] rd_val;
    logic [31:0] wval;
    logic        implemented;
    logic        wr_en;
    logic        cy_run;
    logic        ir_run;
    logic [31:0] pend;
    logic [4:0]  irq_code;
    logic [31:0] tvec_base;

    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};

    always_comb begin
        implemented = 1'b1;
        rd_val      = '0;
        case (csr_addr)
            A_MSTATUS:               rd_val = mstatus_rd;
            A_MIE:                   rd_val = mie_q;
            A_MTVEC:                 rd_val = mtvec_q;
            A_MSCRATCH:              rd_val = mscratch_q;
            A_MEPC:                  rd_val = mepc_q;
            A_MCAUSE:                rd_val = mcause_q;
            A_MTVAL:                 rd_val = mtval_q;
            A_MIP:                   rd_val = mip_q;
            A_MCYCLE, A_CYCLE:       rd_val = mcycle_q[31:0];
            A_MCYCLEH, A_CYCLEH:     rd_val = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:   rd_val = minstret_q[31:0];
            A_MINSTRETH, A_INSTRETH: rd_val = minstret_q[63:32];
`ifdef CSR_MCOUNTINHIBIT_EN
            A_MCNTINH:               rd_val = {29'b0, inhibit_q[1], 1'b0, inhibit_q[0]};
`endif
            default:                 implemented = 1'b0;
        endcase

        csr_illegal = !implemented || (csr_op != 2'b00 && csr_addr[11:10] == 2'b11);
        csr_rdata   = csr_illegal ? '0 : rd_val;

        case (csr_op)
            2'b01:   wval = csr_wdata;
            2'b10:   wval = rd_val | csr_wdata;
            2'b11:   wval = rd_val & ~csr_wdata;
            default: wval = rd_val;
        endcase

        // Trap and MRET own the cycle; any software write alongside them is dropped.
        wr_en = csr_we && csr_op != 2'b00 && !csr_illegal && !trap_in && !mret_taken;
    end

    always_comb begin
        mip_d                       = '0;
        mip_d[3]                    = sw_int_raw;
        mip_d[7]                    = timer_int_raw;
        mip_d[11]                   = ext_int_raw;
        mip_d[16 +: NUM_PLAT_IRQ]   = plat_irq;

        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
`ifdef CSR_MCOUNTINHIBIT_EN
        inhibit_d      = inhibit_q;
        cy_run         = !inhibit_q[0];
        ir_run         = instr_retire && !inhibit_q[1];
`else
        cy_run         = 1'b1;
        ir_run         = instr_retire;
`endif

        if (trap_in) begin
            mepc_d         = {trap_pc[31:1], 1'b0};
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (mret_taken) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (wr_en) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mstatus_mie_d  = wval[3];
                    mstatus_mpie_d = wval[7];
                end
                A_MIE:      mie_d      = wval & MIE_MASK;
                A_MTVEC:    mtvec_d    = wval[1] ? {wval[31:2], mtvec_q[1:0]} : wval;
                A_MSCRATCH: mscratch_d = wval;
                A_MEPC:     mepc_d     = {wval[31:1], 1'b0};
                A_MCAUSE:   mcause_d   = wval;
                A_MTVAL:    mtval_d    = wval;
`ifdef CSR_MCOUNTINHIBIT_EN
                A_MCNTINH:  inhibit_d  = {wval[2], wval[0]};
`endif
                default: ;
            endcase
        end

        // A write to either half of a counter replaces that half and skips its increment.
        mcycle_d = mcycle_q;
        if (wr_en && csr_addr == A_MCYCLE)
            mcycle_d[31:0] = wval;
        else if (wr_en && csr_addr == A_MCYCLEH && HI_WRITABLE)
            mcycle_d[63:32] = wval;
        else if (cy_run)
            mcycle_d = mcycle_q + 64'd1;
        mcycle_d = mcycle_d & CNT_MASK;

        minstret_d = minstret_q;
        if (wr_en && csr_addr == A_MINSTRET)
            minstret_d[31:0] = wval;
        else if (wr_en && csr_addr == A_MINSTRETH && HI_WRITABLE)
            minstret_d[63:32] = wval;
        else if (ir_run)
            minstret_d = minstret_q + 64'd1;
        minstret_d = minstret_d & CNT_MASK;
    end

    // Fixed priority 11 > 3 > 7 > platform lines; the lowest platform index wins.
    always_comb begin
        pend     = mip_q & mie_q;
        irq_code = '0;
        for (int unsigned i = NUM_PLAT_IRQ; i > 0; i--) begin
            if (pend[15 + i]) irq_code = 5'(15 + i);
        end
        if (pend[7])  irq_code = 5'd7;
        if (pend[3])  irq_code = 5'd3;
        if (pend[11]) irq_code = 5'd11;

        irq_cause   = (|pend) ? {1'b1, 26'b0, irq_code} : '0;
        irq_pending = mstatus_mie_q && (|pend);
    end

    always_comb begin
        tvec_base = {mtvec_q[31:2], 2'b00};
        if (mtvec_q[1:0] == 2'b00 || !trap_cause[31])
            trap_target = tvec_base;
        else
            trap_target = tvec_base + {25'b0, trap_cause[4:0], 2'b00};
    end

    assign mepc        = mepc_q;
    assign mstatus_mie = mstatus_mie_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mip_q          <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
`ifdef CSR_MCOUNTINHIBIT_EN
            inhibit_q      <= '0;
`endif
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mip_q          <= mip_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
`ifdef CSR_MCOUNTINHIBIT_EN
            inhibit_q      <= inhibit_d;
`endif
        end
    end

endmodule

// File: tb/tb_csr_file_m.sv
// tb_csr_file_m: directed test-plan steps followed by randomized traffic, all checked
// against a behavioural model of the CSR file kept in this bench.
module tb_csr_file_m;

    localparam int unsigned NIRQ      = 4;
    localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

    logic            clk;
    logic            rst;
    logic [11:0]     csr_addr;
    logic [31:0]     csr_wdata;
    logic            csr_we;
    logic [1:0]      csr_op;
    logic [31:0]     csr_rdata;
    logic            csr_illegal;
    logic            trap_in;
    logic [31:0]     trap_pc;
    logic [31:0]     trap_cause;
    logic [31:0]     trap_tval;
    logic            mret_taken;
    logic            instr_retire;
    logic            timer_int_raw;
    logic            sw_int_raw;
    logic            ext_int_raw;
    logic [NIRQ-1:0] plat_irq;
    logic            irq_pending;
    logic [31:0]     irq_cause;
    logic [31:0]     trap_target;
    logic [31:0]     mepc;
    logic            mstatus_mie;

    csr_file_m #(
        .NUM_PLAT_IRQ(NIRQ),
        .CNT_WIDTH   (64),
        .MTVEC_RESET (MTVEC_RST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_we       (csr_we),
        .csr_op       (csr_op),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .trap_in      (trap_in),
        .trap_pc      (trap_pc),
        .trap_cause   (trap_cause),
        .trap_tval    (trap_tval),
        .mret_taken   (mret_taken),
        .instr_retire (instr_retire),
        .timer_int_raw(timer_int_raw),
        .sw_int_raw   (sw_int_raw),
        .ext_int_raw  (ext_int_raw),
        .plat_irq     (plat_irq),
        .irq_pending  (irq_pending),
        .irq_cause    (irq_cause),
        .trap_target  (trap_target),
        .mepc         (mepc),
        .mstatus_mie  (mstatus_mie)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // Reference model state
    logic [31:0] m_mscratch, m_mepc, m_mcause, m_mtval, m_mtvec, m_mie, m_mip;
    bit          m_MIE, m_MPIE, m_inh_cy, m_inh_ir;
    logic [63:0] m_cyc, m_ins;

    logic [11:0] addrs [20] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                                12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                12'hC02, 12'hC82, 12'h320, 12'h301, 12'hF14, 12'h7C0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mdl_csr(input logic [11:0] a, output bit impl);
        logic [31:0] v;
        impl = 1'b1;
        v    = '0;
        case (a)
            12'h300: v = 32'h1800 | (32'(m_MPIE) << 7) | (32'(m_MIE) << 3);
            12'h304: v = m_mie;
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: v = m_mip;
            12'hB00, 12'hC00: v = m_cyc[31:0];
            12'hB80, 12'hC80: v = m_cyc[63:32];
            12'hB02, 12'hC02: v = m_ins[31:0];
            12'hB82, 12'hC82: v = m_ins[63:32];
`ifdef CSR_MCOUNTINHIBIT_EN
            12'h320: v = (32'(m_inh_ir) << 2) | 32'(m_inh_cy);
`endif
            default: impl = 1'b0;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
        m_mtvec = MTVEC_RST; m_mie = '0; m_mip = '0;
        m_MIE = 1'b0; m_MPIE = 1'b0; m_inh_cy = 1'b0; m_inh_ir = 1'b0;
        m_cyc = '0; m_ins = '0;
    endtask

    task automatic check_all();
        bit          impl, ill;
        logic [31:0] v, pend, exp_cause, base, tt;
        int          prio[$];
        v   = mdl_csr(csr_addr, impl);
        ill = !impl || (csr_op != 2'b00 && csr_addr[11:10] == 2'b11);
        chk("illegal", 32'(csr_illegal), 32'(ill));
        chk("rdata", csr_rdata, ill ? 32'h0 : v);

        pend = m_mip & m_mie;
        prio = '{11, 3, 7};
        for (int i = 0; i < int'(NIRQ); i++) prio.push_back(16 + i);
        exp_cause = '0;
        foreach (prio[k]) if (pend[prio[k]] && exp_cause == 0) exp_cause = 32'h8000_0000 | 32'(prio[k]);
        chk("irq_pending", 32'(irq_pending), 32'(m_MIE && pend != 0));
        chk("irq_cause", irq_cause, exp_cause);

        base = m_mtvec & ~32'h3;
        tt   = ((m_mtvec & 32'h3) != 0 && trap_cause[31]) ? base + ((trap_cause & 32'h1F) << 2) : base;
        chk("trap_target", trap_target, tt);
        chk("mepc", mepc, m_mepc);
        chk("mstatus_mie", 32'(mstatus_mie), 32'(m_MIE));
    endtask

    task automatic model_step();
        bit          impl, ill, do_wr;
        logic [31:0] old, nv;
        logic [63:0] nc, ni;
        old   = mdl_csr(csr_addr, impl);
        ill   = !impl || (csr_op != 2'b00 && csr_addr[11:10] == 2'b11);
        do_wr = csr_we && csr_op != 2'b00 && !ill && !trap_in && !mret_taken;
        case (csr_op)
            2'b01:   nv = csr_wdata;
            2'b10:   nv = old | csr_wdata;
            default: nv = old & ~csr_wdata;
        endcase

        nc = m_cyc + (m_inh_cy ? 64'd0 : 64'd1);
        ni = m_ins + ((instr_retire && !m_inh_ir) ? 64'd1 : 64'd0);
        if (do_wr) begin
            if (csr_addr == 12'hB00) nc = {m_cyc[63:32], nv};
            if (csr_addr == 12'hB80) nc = {nv, m_cyc[31:0]};
            if (csr_addr == 12'hB02) ni = {m_ins[63:32], nv};
            if (csr_addr == 12'hB82) ni = {nv, m_ins[31:0]};
        end

        if (trap_in) begin
            m_mepc = trap_pc & ~32'h1; m_mcause = trap_cause; m_mtval = trap_tval;
            m_MPIE = m_MIE; m_MIE = 1'b0;
        end else if (mret_taken) begin
            m_MIE = m_MPIE; m_MPIE = 1'b1;
        end else if (do_wr) begin
            case (csr_addr)
                12'h300: begin m_MIE = nv[3]; m_MPIE = nv[7]; end
                12'h304: m_mie = nv & (32'h0000_0888 | (((32'h1 << NIRQ) - 1) << 16));
                12'h305: m_mtvec = (nv[1:0] >= 2'd2) ? ((nv & ~32'h3) | (m_mtvec & 32'h3)) : nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~32'h1;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'h320: begin m_inh_cy = nv[0]; m_inh_ir = nv[2]; end
                default: ;
            endcase
        end
        m_cyc = nc;
        m_ins = ni;
        m_mip = (32'(sw_int_raw) << 3) | (32'(timer_int_raw) << 7) | (32'(ext_int_raw) << 11) |
                (32'(plat_irq) << 16);
    endtask

    // Called just after a falling edge with inputs applied; ends at the next falling edge.
    task automatic cyc();
        #1;
        check_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
        cyc();
        csr_we = 1'b0; csr_op = 2'b00;
    endtask

    task automatic csr_x(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                         input logic [31:0] exp_old, input string tag);
        csr_we = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
        #1 chk(tag, csr_rdata, exp_old);
        cyc();
        csr_we = 1'b0; csr_op = 2'b00;
    endtask

    task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_we = 1'b0; csr_op = 2'b00; csr_addr = a;
        #1 chk(tag, csr_rdata, exp);
    endtask

    task automatic peek_irq(input logic exp_p, input logic [31:0] exp_c);
        #1;
        chk("plan_irq_pending", 32'(irq_pending), 32'(exp_p));
        chk("plan_irq_cause", irq_cause, exp_c);
    endtask

    logic [31:0] cexp, iexp;

    initial begin
        rst = 1'b0; csr_addr = '0; csr_wdata = '0; csr_we = 1'b0; csr_op = 2'b00;
        trap_in = 1'b0; trap_pc = '0; trap_cause = '0; trap_tval = '0; mret_taken = 1'b0;
        instr_retire = 1'b0; timer_int_raw = 1'b0; sw_int_raw = 1'b0; ext_int_raw = 1'b0;
        plat_irq = '0;
        #1 rst = 1'b1;
        #2;
        chk("rst_irq_pending", 32'(irq_pending), 32'h0);
        chk("rst_irq_cause", irq_cause, 32'h0);
        chk("rst_mepc", mepc, 32'h0);
        chk("rst_mstatus_mie", 32'(mstatus_mie), 32'h0);
        chk("rst_trap_target", trap_target, MTVEC_RST);
        peek("rst_mtvec", 12'h305, MTVEC_RST);
        peek("rst_mstatus", 12'h300, 32'h0000_1800);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Atomic read-modify-write on mscratch
        csr_x(2'b01, 12'h340, 32'hF0F0_0000, 32'h0000_0000, "rw_old");
        csr_x(2'b10, 12'h340, 32'h0000_00FF, 32'hF0F0_0000, "rs_old");
        csr_x(2'b11, 12'h340, 32'hF000_0000, 32'hF0F0_00FF, "rc_old");
        peek("mscratch_final", 12'h340, 32'h00F0_00FF);

        // Interrupt arbitration and latency
        csr(2'b01, 12'h304, 32'h0001_0880);
        csr(2'b01, 12'h300, 32'h0000_0008);
        plat_irq = 4'b0001; timer_int_raw = 1'b1; ext_int_raw = 1'b1;
        #1 chk("irq_not_yet", 32'(irq_pending), 32'h0);
        cyc();
        peek_irq(1'b1, 32'h8000_000B);
        ext_int_raw = 1'b0;
        cyc();
        peek_irq(1'b1, 32'h8000_0007);
        timer_int_raw = 1'b0;
        cyc();
        peek_irq(1'b1, 32'h8000_0010);
        plat_irq = '0;
        cyc();
        peek_irq(1'b0, 32'h0);

        // Vectored trap and MRET
        csr(2'b01, 12'h305, 32'h0000_0201);
        trap_in = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_1234; trap_tval = 32'hDEAD_BEEF;
        #1 chk("trap_target_vec", trap_target, 32'h0000_021C);
        cyc();
        trap_in = 1'b0;
        #1;
        chk("trap_mepc", mepc, 32'h0000_1234);
        chk("trap_mie_cleared", 32'(mstatus_mie), 32'h0);
        peek("trap_mstatus", 12'h300, 32'h0000_1880);
        mret_taken = 1'b1;
        cyc();
        mret_taken = 1'b0;
        #1 chk("mret_mie", 32'(mstatus_mie), 32'h1);

        // Trap wins over a same-cycle mepc write
        trap_in = 1'b1; trap_pc = 32'h0000_2000; trap_cause = 32'h0000_0002;
        csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'h0000_5555;
        cyc();
        trap_in = 1'b0; csr_we = 1'b0; csr_op = 2'b00;
        peek("trap_vs_write_mepc", 12'h341, 32'h0000_2000);
        peek("trap_vs_write_mcause", 12'h342, 32'h0000_0002);

        // mcycle carry into the high half, and read-only shadow
        csr(2'b01, 12'hB80, 32'h0);
        csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
        cyc();
        cyc();
        peek("mcycle_lo_wrap", 12'hB00, 32'h1);
        peek("mcycle_hi_wrap", 12'hB80, 32'h1);
        csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'hC00; csr_wdata = 32'h0;
        #1 chk("shadow_write_illegal", 32'(csr_illegal), 32'h1);
        cyc();
        csr_we = 1'b0; csr_op = 2'b00;
        peek("mcycle_after_shadow", 12'hB00, 32'h2);

`ifdef CSR_MCOUNTINHIBIT_EN
        csr(2'b01, 12'h320, 32'h5);
        cexp = m_cyc[31:0];
        iexp = m_ins[31:0];
        instr_retire = 1'b1;
        repeat (10) cyc();
        peek("inhibit_mcycle", 12'hB00, cexp);
        peek("inhibit_minstret", 12'hB02, iexp);
        csr(2'b01, 12'h320, 32'h0);
        repeat (3) cyc();
        instr_retire = 1'b0;
        peek("resume_mcycle", 12'hB00, cexp + 32'd3);
        peek("resume_minstret", 12'hB02, iexp + 32'd3);
`else
        csr_we = 1'b1; csr_op = 2'b01; csr_addr = 12'h320; csr_wdata = 32'h5;
        #1 chk("mcountinhibit_absent", 32'(csr_illegal), 32'h1);
        cyc();
        csr_we = 1'b0; csr_op = 2'b00;
`endif

        // Asynchronous reset between clock edges
        csr(2'b01, 12'h341, 32'h000A_BCD0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_mepc", mepc, 32'h0);
        chk("async_rst_mie", 32'(mstatus_mie), 32'h0);
        chk("async_rst_trap_target", trap_target, MTVEC_RST);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        peek("post_rst_mtvec", 12'h305, MTVEC_RST);

        // Randomized traffic
        repeat (400) begin
            csr_addr     = addrs[$urandom_range(0, 19)];
            csr_we       = 1'($urandom_range(0, 1));
            csr_op       = 2'($urandom_range(0, 3));
            csr_wdata    = $urandom;
            trap_in      = ($urandom_range(0, 15) == 0);
            mret_taken   = ($urandom_range(0, 15) == 0);
            trap_pc      = $urandom;
            trap_cause   = $urandom;
            trap_tval    = $urandom;
            instr_retire = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) sw_int_raw = ~sw_int_raw;
            if ($urandom_range(0, 7) == 0) timer_int_raw = ~timer_int_raw;
            if ($urandom_range(0, 7) == 0) ext_int_raw = ~ext_int_raw;
            if ($urandom_range(0, 3) == 0) plat_irq = plat_irq ^ NIRQ'($urandom_range(0, 15));
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
